// File: rtl/rv32i_alu_pkg.sv
// Shared RV32I ALU definitions: datapath width and ALU operation encoding.
// Used by the ALU, the instruction decoder and imm_gen.
package rv32i_alu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SHAMT_W = 5;

  // R-type ops are {funct7[5], funct3}; branch compares and PASSB use the spare codes
  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_EQ    = 4'b1001,
    ALU_NE    = 4'b1010,
    ALU_GE    = 4'b1011,
    ALU_GEU   = 4'b1100,
    ALU_SRA   = 4'b1101,
    ALU_PASSB = 4'b1110,
    ALU_RSVD  = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/rv32i_alu_if.sv
// ALU operand/result bundle.
//   alu_op   operation select (alu_op_e)
//   alu_in1  operand A (rs1 or PC)
//   alu_in2  operand B (rs2 or immediate)
//   alu_out  registered result
//   alu_zero registered "result is zero" flag (only with RV32I_ALU_ZERO_FLAG_EN)
// master: the core issuing operations; slave: the ALU.
interface rv32i_alu_if
  import rv32i_alu_pkg::*;
#(
  parameter int unsigned XLEN = rv32i_alu_pkg::XLEN
);

  alu_op_e           alu_op;
  logic [XLEN-1:0]   alu_in1;
  logic [XLEN-1:0]   alu_in2;
  logic [XLEN-1:0]   alu_out;
`ifdef RV32I_ALU_ZERO_FLAG_EN
  logic              alu_zero;
`endif

  modport master (
    output alu_op, alu_in1, alu_in2,
    input  alu_out
`ifdef RV32I_ALU_ZERO_FLAG_EN
    , input alu_zero
`endif
  );

  modport slave (
    input  alu_op, alu_in1, alu_in2,
    output alu_out
`ifdef RV32I_ALU_ZERO_FLAG_EN
    , output alu_zero
`endif
  );

endinterface

// File: rtl/rv32i_alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA.
//   data_in      value to shift
//   shamt        shift amount (0..31)
//   shift_left   1 = logical left, 0 = right
//   shift_arith  for right shifts, 1 = replicate sign bit
//   shift_out_c  shifted result (combinational)
module rv32i_alu_shifter
  import rv32i_alu_pkg::*;
#(
  parameter int unsigned XLEN = rv32i_alu_pkg::XLEN
) (
  input  logic [XLEN-1:0]    data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               shift_left,
  input  logic               shift_arith,
  output logic [XLEN-1:0]    shift_out_c
);

  always_comb begin
    shift_out_c = '0;
    if (shift_left) begin
      shift_out_c = data_in << shamt;
    end else if (shift_arith) begin
      shift_out_c = XLEN'($signed(data_in) >>> shamt);
    end else begin
      shift_out_c = data_in >> shamt;
    end
  end

endmodule

// File: rtl/rv32i_alu.sv
// Registered RV32I integer ALU: result appears one clock after the operands.
//   clk     system clock
//   reset   synchronous active-high reset (clears alu_out)
//   alu_if  slave side of rv32i_alu_if (op, operands, result)
// Optional macro RV32I_ALU_ZERO_FLAG_EN adds the registered alu_zero flag,
// set to 1 by reset.
module rv32i_alu
  import rv32i_alu_pkg::*;
#(
  parameter int unsigned XLEN = rv32i_alu_pkg::XLEN
) (
  input  logic        clk,
  input  logic        reset,
  rv32i_alu_if.slave  alu_if
);

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] shift_c;
  logic [XLEN-1:0] result_c;
  logic            lt_s_c;
  logic            lt_u_c;
  logic            shift_left_c;
  logic            shift_arith_c;

  assign a = alu_if.alu_in1;
  assign b = alu_if.alu_in2;

  assign lt_s_c        = $signed(a) < $signed(b);
  assign lt_u_c        = a < b;
  assign shift_left_c  = (alu_if.alu_op == ALU_SLL);
  assign shift_arith_c = (alu_if.alu_op == ALU_SRA);

  // Only the low 5 bits of B select the shift amount
  rv32i_alu_shifter #(.XLEN(XLEN)) u_shifter (
    .data_in     (a),
    .shamt       (b[SHAMT_W-1:0]),
    .shift_left  (shift_left_c),
    .shift_arith (shift_arith_c),
    .shift_out_c (shift_c)
  );

  // Next result; compares are zero-extended single bits
  always_comb begin
    result_c = '0;
    case (alu_if.alu_op)
      ALU_ADD:   result_c = a + b;
      ALU_SUB:   result_c = a - b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:   result_c = shift_c;
      ALU_SLT:   result_c = XLEN'(lt_s_c);
      ALU_SLTU:  result_c = XLEN'(lt_u_c);
      ALU_XOR:   result_c = a ^ b;
      ALU_OR:    result_c = a | b;
      ALU_AND:   result_c = a & b;
      ALU_EQ:    result_c = XLEN'(a == b);
      ALU_NE:    result_c = XLEN'(a != b);
      ALU_GE:    result_c = XLEN'(!lt_s_c);
      ALU_GEU:   result_c = XLEN'(!lt_u_c);
      ALU_PASSB: result_c = b;
      default:   result_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_if.alu_out <= '0;
    end else begin
      alu_if.alu_out <= result_c;
    end
  end

`ifdef RV32I_ALU_ZERO_FLAG_EN
  // Flag tracks the value being loaded into alu_out; reset value 0 counts as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_if.alu_zero <= 1'b1;
    end else begin
      alu_if.alu_zero <= (result_c == '0);
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_alu.sv
// Scoreboard bench for rv32i_alu: directed vectors push expected results,
// a monitor pops and compares one cycle after each issued operation.
module tb_rv32i_alu;
  import rv32i_alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  logic issue_v;
  exp_t sb[$];
  int   checks;
  int   passed;

  rv32i_alu_if #(.XLEN(32)) alu_if ();

  rv32i_alu #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .alu_if (alu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, want);
  endtask

  // Drive one operation on the falling edge and record its expected result
  task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic rst, input logic [31:0] res, input string nm);
    exp_t e;
    @(negedge clk);
    alu_if.alu_op  = op;
    alu_if.alu_in1 = a;
    alu_if.alu_in2 = b;
    reset          = rst;
    issue_v        = 1'b1;
    e.res  = res;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: an op issued before this edge produces its result after it
  initial begin
    logic sampled;
    exp_t e;
    forever begin
      @(posedge clk);
      sampled = issue_v;
      #1;
      if (sampled) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check(e.name, alu_if.alu_out, e.res);
`ifdef RV32I_ALU_ZERO_FLAG_EN
          check({e.name, "_zero"}, 32'(alu_if.alu_zero), 32'(e.res == 32'd0));
`endif
        end
      end
    end
  end

  initial begin
    int waited;
    checks  = 0;
    passed  = 0;
    issue_v = 1'b0;
    reset   = 1'b1;
    alu_if.alu_op  = ALU_ADD;
    alu_if.alu_in1 = '0;
    alu_if.alu_in2 = '0;
    repeat (2) @(negedge clk);

    // reset and hold
    issue(ALU_ADD,   32'd5,        32'd7,        1'b1, 32'h0000_0000, "reset_add");
    issue(ALU_ADD,   32'd5,        32'd7,        1'b0, 32'd12,        "add_5_7");
    // add/sub wrap
    issue(ALU_ADD,   32'hFFFF_FFFF, 32'd1,       1'b0, 32'h0000_0000, "add_wrap");
    issue(ALU_SUB,   32'd0,        32'd1,        1'b0, 32'hFFFF_FFFF, "sub_wrap");
    issue(ALU_SUB,   32'd10,       32'd3,        1'b0, 32'd7,         "sub_10_3");
    // shifts
    issue(ALU_SLL,   32'd1,        32'd31,       1'b0, 32'h8000_0000, "sll_31");
    issue(ALU_SRL,   32'h8000_0000, 32'd31,      1'b0, 32'h0000_0001, "srl_31");
    issue(ALU_SRA,   32'h8000_0000, 32'd4,       1'b0, 32'hF800_0000, "sra_4");
    issue(ALU_SLL,   32'd3,        32'h0000_0021, 1'b0, 32'd6,        "sll_hi_ignored");
    issue(ALU_SRA,   32'h8000_0000, 32'd31,      1'b0, 32'hFFFF_FFFF, "sra_31");
    issue(ALU_SRL,   32'h1234_5678, 32'd0,       1'b0, 32'h1234_5678, "srl_0");
    issue(ALU_SRA,   32'h7000_0000, 32'd4,       1'b0, 32'h0700_0000, "sra_pos");
    issue(ALU_SRL,   32'hF000_0000, 32'h0000_0104, 1'b0, 32'h0F00_0000, "srl_4");
    // signed vs unsigned compares
    issue(ALU_SLT,   32'hFFFF_FFFF, 32'd1,       1'b0, 32'd1, "slt_neg");
    issue(ALU_SLTU,  32'hFFFF_FFFF, 32'd1,       1'b0, 32'd0, "sltu_big");
    issue(ALU_GE,    32'hFFFF_FFFF, 32'd1,       1'b0, 32'd0, "ge_neg");
    issue(ALU_GEU,   32'hFFFF_FFFF, 32'd1,       1'b0, 32'd1, "geu_big");
    issue(ALU_SLT,   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd1, "slt_minint");
    issue(ALU_GE,    32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'd1, "ge_maxint");
    issue(ALU_GE,    32'd5,        32'd5,        1'b0, 32'd1, "ge_eq");
    issue(ALU_SLTU,  32'd5,        32'd5,        1'b0, 32'd0, "sltu_eq");
    issue(ALU_EQ,    32'd5,        32'd5,        1'b0, 32'd1, "eq_same");
    issue(ALU_NE,    32'd5,        32'd5,        1'b0, 32'd0, "ne_same");
    issue(ALU_EQ,    32'd5,        32'd6,        1'b0, 32'd0, "eq_diff");
    issue(ALU_NE,    32'd5,        32'd6,        1'b0, 32'd1, "ne_diff");
    // logic, pass, reserved
    issue(ALU_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'h00F0_00F0, "and");
    issue(ALU_OR,    32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'hFFF0_FFF0, "or");
    issue(ALU_XOR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'hFF00_FF00, "xor");
    issue(ALU_PASSB, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'h0FF0_0FF0, "passb");
    issue(ALU_RSVD,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'h0000_0000, "rsvd");
    // back-to-back, then mid-stream reset
    issue(ALU_ADD,   32'd1,        32'd1,        1'b0, 32'd2, "b2b_add");
    issue(ALU_SUB,   32'd9,        32'd4,        1'b0, 32'd5, "b2b_sub");
    issue(ALU_XOR,   32'd3,        32'd1,        1'b0, 32'd2, "b2b_xor");
    issue(ALU_ADD,   32'd1,        32'd1,        1'b0, 32'd2, "b2b2_add");
    issue(ALU_SUB,   32'd9,        32'd4,        1'b0, 32'd5, "b2b2_sub");
    issue(ALU_XOR,   32'd3,        32'd1,        1'b1, 32'd0, "b2b2_reset");
    issue(ALU_SUB,   32'd4,        32'd4,        1'b0, 32'd0, "sub_4_4");

    @(negedge clk);
    issue_v = 1'b0;
    waited  = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) check("drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
